apb_master_arbiter: RTL and testbench
=====================================

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameters, one per line:
- ADDR_WIDTH, default 4, APB address width.
- DATA_WIDTH, default 8, APB data width.
- TIMEOUT, default 15, maximum ACCESS cycles without pready before abort.

REQ-002 Ports, one per line (name, direction, width, meaning):
- pclk, in, 1, sole clock; all logic is sampled on its rising edge.
- preset, in, 1, synchronous, active-high reset.
- req_valid, in, 2, per-requester transfer request; bit i belongs to requester i.
- req_write, in, 2, per-requester direction; 1 = write, 0 = read.
- req_addr, in, 2*ADDR_WIDTH, per-requester address; requester i uses slice i.
- req_wdata, in, 2*DATA_WIDTH, per-requester write data; requester i uses slice i.
- req_ack, out, 2, one-cycle completion pulse to the served requester.
- resp_rdata, out, DATA_WIDTH, read data; valid while req_ack is high.
- resp_err, out, 1, error flag; valid while req_ack is high.
- psel, out, 1, APB select.
- penable, out, 1, APB enable.
- pwrite, out, 1, APB direction.
- paddr, out, ADDR_WIDTH, APB address.
- pwdata, out, DATA_WIDTH, APB write data.
- prdata, in, DATA_WIDTH, APB read data.
- pready, in, 1, APB ready.
- pslverr, in, 1, APB slave error.

Function
REQ-003 The block SHALL share one APB master port between two requesters, with one transfer outstanding at a time.
REQ-004 The FSM SHALL have states IDLE, SETUP, ACCESS and DONE.
- IDLE -> SETUP when any req_valid bit is high.
- SETUP -> ACCESS unconditionally.
- ACCESS -> DONE on pready=1 or on timeout.
- DONE -> IDLE unconditionally.
REQ-005 In IDLE, arbitration SHALL be round-robin:
- If only one requester is valid, it is granted.
- If both are valid, the requester not granted last is granted.
- After reset, the last-grant pointer is 1, so requester 0 wins the first tie.
REQ-006 On grant, the block SHALL latch the granted requester's write, addr and wdata; paddr, pwrite and pwdata SHALL come from the latch and stay stable through SETUP and ACCESS.
REQ-007 APB outputs by state:
- SETUP: psel=1, penable=0.
- ACCESS: psel=1, penable=1.
- IDLE and DONE: psel=0, penable=0.
REQ-008 In ACCESS, a wait-state counter SHALL:
- clear on entry to ACCESS;
- increment each ACCESS cycle in which pready=0;
- trigger a timeout when it reaches TIMEOUT with pready still 0, forcing ACCESS -> DONE.
REQ-009 On the ACCESS cycle where pready=1, the block SHALL register prdata (reads only; hold the previous value on writes) and register pslverr.
REQ-010 On timeout, the block SHALL register resp_err=1 and leave resp_rdata unchanged.
REQ-011 In DONE, req_ack SHALL pulse high for exactly one cycle, on the granted bit only.
REQ-012 resp_rdata and resp_err SHALL hold their values until the next DONE.
REQ-013 Timing:
- Minimum latency from req_valid (sampled in IDLE) to req_ack is 4 cycles with zero wait states.
- Throughput is one transfer per 4 cycles at zero wait states.
REQ-014 Requester obligations and input sampling:
- A requester SHALL hold req_valid and its fields until its req_ack.
- A deasserted req_valid SHALL be ignored except in IDLE.
- Changes to the granted requester's inputs after grant SHALL have no effect.
REQ-015 A requester that holds valid through its own ack SHALL be re-arbitrated in the following IDLE; with both valid, grants SHALL alternate 0,1,0,1.
REQ-016 psel and penable SHALL never be asserted in the same cycle as req_ack.

Reset
REQ-017 With preset=1 at a pclk edge, the following SHALL hold in the next cycle:
- state=IDLE;
- psel=0, penable=0, pwrite=0;
- paddr=0, pwdata=0;
- req_ack=0, resp_rdata=0, resp_err=0;
- wait counter=0, last-grant pointer=1.
REQ-018 Reset asserted mid-transfer (SETUP or ACCESS) SHALL abort without generating req_ack.
REQ-019 Reset SHALL take priority over every other input.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single write: req_valid=01, write=1, addr=3, wdata=0xA5, pready=1 -> SETUP then ACCESS with paddr=3, pwdata=0xA5, pwrite=1; req_ack=01 four cycles after the request; resp_err=0.
- Read with 2 wait states: req1 read addr=5, prdata=0x3C with pready low for 2 ACCESS cycles -> penable high for 3 cycles; req_ack=10; resp_rdata=0x3C.
- Simultaneous requests held for 4 transfers -> grants in order 0,1,0,1; no back-to-back psel without an intervening IDLE cycle.
- Timeout: pready held 0 -> ACCESS lasts TIMEOUT+1=16 cycles, then req_ack pulses with resp_err=1 and resp_rdata unchanged.
- Slave error: pslverr=1 together with pready=1 -> resp_err=1 on ack; the next clean transfer returns resp_err=0.
- Reset in ACCESS: assert preset during a wait state -> psel=0 next cycle, no req_ack, and the first post-reset tie is granted to requester 0.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master with round-robin arbitration.
// One transfer is outstanding at a time. Each transfer walks IDLE -> SETUP -> ACCESS -> DONE.
// A wait-state counter aborts an ACCESS phase that the slave never completes.
module apb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ack,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    last_q, last_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    pick;

  // On a tie the requester that was not granted last wins.
  assign pick = (req_valid == 2'b11) ? ~last_q : req_valid[1];

  // State and data registers; synchronous reset wins over everything.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: arbitration, request latching, wait counting and response capture.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          gnt_d   = pick;
          last_d  = pick;
          write_d = pick ? req_write[1] : req_write[0];
          addr_d  = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          wdata_d = pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (pready) begin
          // Writes leave the last read data in place.
          if (!write_q) rdata_d = prdata;
          err_d   = pslverr;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // APB and response outputs decoded from the registered state.
  always_comb begin
    psel       = (state_q == StSetup) || (state_q == StAccess);
    penable    = (state_q == StAccess);
    pwrite     = write_q;
    paddr      = addr_q;
    pwdata     = wdata_q;
    resp_rdata = rdata_q;
    resp_err   = err_q;
    req_ack    = 2'b00;
    if (state_q == StDone) req_ack = gnt_q ? 2'b10 : 2'b01;
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter. Inputs are driven and outputs are sampled on the
// falling clock edge.
module tb_apb_master_arbiter;

  logic       pclk = 1'b0;
  logic       preset;
  logic [1:0] req_valid;
  logic [1:0] req_write;
  logic [7:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0] req_ack;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .TIMEOUT   (15)
  ) u_dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  // Runs one transfer from the IDLE cycle with requests already driven, ending in DONE.
  // With tmo set the slave never answers and the transfer must abort after waits+1 cycles.
  task automatic xfer(input string tag, input logic exp_gnt, input logic [3:0] exp_addr,
                      input logic exp_wr, input logic [7:0] exp_wd, input int waits,
                      input bit tmo, input logic [7:0] rd, input logic serr);
    int pen;
    prdata  = rd;
    pslverr = serr;
    pready  = 1'b0;
    step();
    check_eq({tag, ".setup_psel"}, psel, 1);
    check_eq({tag, ".setup_penable"}, penable, 0);
    check_eq({tag, ".paddr"}, paddr, exp_addr);
    check_eq({tag, ".pwrite"}, pwrite, exp_wr);
    check_eq({tag, ".pwdata"}, pwdata, exp_wd);
    check_eq({tag, ".setup_ack"}, req_ack, 0);
    pen = 0;
    for (int i = 0; i <= waits; i++) begin
      step();
      if (psel && penable && req_ack == 2'b00 && paddr == exp_addr) pen++;
      pready = (i == waits) && !tmo;
    end
    check_eq({tag, ".access_cycles"}, pen, waits + 1);
    step();
    check_eq({tag, ".ack"}, req_ack, exp_gnt ? 2'b10 : 2'b01);
    check_eq({tag, ".done_psel"}, {psel, penable}, 0);
    pready = 1'b0;
  endtask

  initial begin
    preset    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    prdata    = 8'h00;
    pready    = 1'b0;
    pslverr   = 1'b0;
    step();
    step();
    check_eq("rst.apb", {psel, penable, pwrite, paddr, pwdata}, 0);
    check_eq("rst.resp", {req_ack, resp_rdata, resp_err}, 0);
    preset = 1'b0;

    // Single write from requester 0.
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h03; req_wdata = 16'h00A5;
    xfer("wr0", 1'b0, 4'h3, 1'b1, 8'hA5, 0, 1'b0, 8'h00, 1'b0);
    check_eq("wr0.err", resp_err, 0);
    req_valid = 2'b00;
    step();
    check_eq("wr0.idle_ack", req_ack, 0);

    // Read from requester 1 with two wait states.
    req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h50; req_wdata = 16'h1100;
    xfer("rd1", 1'b1, 4'h5, 1'b0, 8'h11, 2, 1'b0, 8'h3C, 1'b0);
    check_eq("rd1.rdata", resp_rdata, 8'h3C);
    check_eq("rd1.err", resp_err, 0);
    req_valid = 2'b00;
    step();

    // Both requesters held for four reads: grants alternate starting with 0.
    req_valid = 2'b11; req_write = 2'b00; req_addr = 8'h92; req_wdata = 16'h2211;
    xfer("rr0", 1'b0, 4'h2, 1'b0, 8'h11, 0, 1'b0, 8'h40, 1'b0);
    check_eq("rr0.rdata", resp_rdata, 8'h40);
    step();
    check_eq("rr0.gap_psel", psel, 0);
    xfer("rr1", 1'b1, 4'h9, 1'b0, 8'h22, 0, 1'b0, 8'h41, 1'b0);
    check_eq("rr1.rdata", resp_rdata, 8'h41);
    step();
    check_eq("rr1.gap_psel", psel, 0);
    xfer("rr2", 1'b0, 4'h2, 1'b0, 8'h11, 1, 1'b0, 8'h42, 1'b0);
    check_eq("rr2.rdata", resp_rdata, 8'h42);
    step();
    check_eq("rr2.gap_psel", psel, 0);
    xfer("rr3", 1'b1, 4'h9, 1'b0, 8'h22, 0, 1'b0, 8'h43, 1'b0);
    check_eq("rr3.rdata", resp_rdata, 8'h43);
    req_valid = 2'b00;
    step();

    // Timeout on a read: ACCESS lasts 16 cycles, error set, read data untouched.
    req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h07; req_wdata = 16'h0033;
    xfer("tmo", 1'b0, 4'h7, 1'b0, 8'h33, 15, 1'b1, 8'hEE, 1'b0);
    check_eq("tmo.err", resp_err, 1);
    check_eq("tmo.rdata", resp_rdata, 8'h43);
    req_valid = 2'b00;
    step();
    check_eq("tmo.hold_err", resp_err, 1);

    // Slave error on a write, then a clean read clears the error.
    req_valid = 2'b10; req_write = 2'b10; req_addr = 8'h10; req_wdata = 16'h5A00;
    xfer("serr", 1'b1, 4'h1, 1'b1, 8'h5A, 0, 1'b0, 8'hDD, 1'b1);
    check_eq("serr.err", resp_err, 1);
    check_eq("serr.rdata", resp_rdata, 8'h43);
    req_valid = 2'b00;
    step();
    req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h02; req_wdata = 16'h0000;
    xfer("clean", 1'b0, 4'h2, 1'b0, 8'h00, 0, 1'b0, 8'h77, 1'b0);
    check_eq("clean.err", resp_err, 0);
    check_eq("clean.rdata", resp_rdata, 8'h77);
    req_valid = 2'b00;
    step();

    // Reset during a wait state aborts silently and restores the tie-break to requester 0.
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h04; req_wdata = 16'h0099;
    pready = 1'b0;
    step();
    step();
    check_eq("rst_mid.in_access", {psel, penable}, 2'b11);
    preset = 1'b1;
    step();
    check_eq("rst_mid.psel", {psel, penable}, 0);
    check_eq("rst_mid.ack", req_ack, 0);
    check_eq("rst_mid.regs", {paddr, pwdata, resp_rdata, resp_err}, 0);
    preset = 1'b0;
    req_valid = 2'b11; req_write = 2'b00; req_addr = 8'h86; req_wdata = 16'h0000;
    xfer("post_rst", 1'b0, 4'h6, 1'b0, 8'h00, 0, 1'b0, 8'h5C, 1'b0);
    check_eq("post_rst.rdata", resp_rdata, 8'h5C);
    req_valid = 2'b00;
    step();
    check_eq("post_rst.idle", {psel, req_ack}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
